// File: rtl/rc4_encrypt_message_if.sv
// rtl/rc4_encrypt_message_if.sv - control, S-memory, plaintext and ciphertext signals of the RC4 encryptor.
interface rc4_encrypt_message_if;
  logic       start;
  logic       finish;
  logic       pt_invalid;
  logic [7:0] s_address;
  logic [7:0] s_write_data;
  logic       s_write;
  logic [7:0] s_read_data;
  logic [4:0] pt_address;
  logic [7:0] pt_read_data;
  logic [4:0] ct_address;
  logic [7:0] ct_write_data;
  logic       ct_write;

  modport slave (
    input  start, s_read_data, pt_read_data,
    output finish, pt_invalid, s_address, s_write_data, s_write,
           pt_address, ct_address, ct_write_data, ct_write
  );

  modport master (
    output start, s_read_data, pt_read_data,
    input  finish, pt_invalid, s_address, s_write_data, s_write,
           pt_address, ct_address, ct_write_data, ct_write
  );
endinterface

// File: rtl/rc4_encrypt_message.sv
// rtl/rc4_encrypt_message.sv - RC4 PRGA encryptor over a pre-shuffled S memory.
// Eleven states per byte; memory data is sampled one state after each read address is held.
module rc4_encrypt_message #(
  parameter int MSG_LEN = 32
) (
  input  logic clk,
  input  logic reset,
  rc4_encrypt_message_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, READ_SI, WAIT_SI, CALC_J, READ_SJ, WAIT_SJ, SWAP_I, SWAP_J,
    READ_F, WAIT_F, WRITE_CT, NEXT, DONE
  } state_t;

  state_t     state_q;
  logic [7:0] i_q, j_q, si_q, sj_q;
  logic [4:0] k_q;
  logic       pt_invalid_q;
  logic [7:0] f_idx;
  logic       pt_ok;

  assign f_idx = si_q + sj_q;
  assign pt_ok = (bus.pt_read_data == 8'h20) ||
                 ((bus.pt_read_data >= 8'h61) && (bus.pt_read_data <= 8'h7A));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      i_q          <= 8'd0;
      j_q          <= 8'd0;
      si_q         <= 8'd0;
      sj_q         <= 8'd0;
      k_q          <= 5'd0;
      pt_invalid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          i_q          <= 8'd1;
          j_q          <= 8'd0;
          k_q          <= 5'd0;
          pt_invalid_q <= 1'b0;
          state_q      <= READ_SI;
        end
        READ_SI: state_q <= WAIT_SI;
        WAIT_SI: state_q <= CALC_J;
        CALC_J: begin
          si_q    <= bus.s_read_data;
          j_q     <= j_q + bus.s_read_data;
          state_q <= READ_SJ;
        end
        READ_SJ: state_q <= WAIT_SJ;
        WAIT_SJ: state_q <= SWAP_I;
        SWAP_I: begin
          sj_q    <= bus.s_read_data;
          state_q <= SWAP_J;
        end
        SWAP_J: state_q <= READ_F;
        READ_F: state_q <= WAIT_F;
        WAIT_F: state_q <= WRITE_CT;
        WRITE_CT: begin
          if (!pt_ok) pt_invalid_q <= 1'b1;
          state_q <= NEXT;
        end
        NEXT: begin
          if (k_q == 5'(MSG_LEN - 1)) begin
            state_q <= DONE;
          end else begin
            i_q     <= i_q + 8'd1;
            k_q     <= k_q + 5'd1;
            state_q <= READ_SI;
          end
        end
        DONE: if (!bus.start) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Strobes decode from state so an async reset removes them in the same cycle.
  always_comb begin
    bus.s_address     = 8'd0;
    bus.s_write_data  = 8'd0;
    bus.s_write       = 1'b0;
    bus.ct_address    = 5'd0;
    bus.ct_write_data = 8'd0;
    bus.ct_write      = 1'b0;
    case (state_q)
      READ_SI, WAIT_SI, CALC_J: bus.s_address = i_q;
      READ_SJ, WAIT_SJ:         bus.s_address = j_q;
      SWAP_I: begin
        bus.s_address    = i_q;
        bus.s_write_data = bus.s_read_data;
        bus.s_write      = 1'b1;
      end
      SWAP_J: begin
        bus.s_address    = j_q;
        bus.s_write_data = si_q;
        bus.s_write      = 1'b1;
      end
      READ_F, WAIT_F: bus.s_address = f_idx;
      WRITE_CT: begin
        bus.s_address     = f_idx;
        bus.ct_address    = k_q;
        bus.ct_write_data = bus.s_read_data ^ bus.pt_read_data;
        bus.ct_write      = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.finish     = (state_q == DONE);
  assign bus.pt_invalid = pt_invalid_q;
  assign bus.pt_address = k_q;

endmodule
